control_sequencer: RTL and testbench

Hardwired control unit that drives the datapath's register-transfer strobes, replacing the hand-sequenced stimulus now used in datapath benches. It runs the shared fetch (T0–T2), decodes `ir[31:27]`, then steps the execute phase for ALU register, ALU immediate, load, store, nop and halt. It sits beside the datapath, reads back the IR, and is the sole driver of its control inputs.

---
 rtl/cpu_ctrl_pkg.sv | 149 ++++++++++++++
 rtl/opcode_decoder.sv | 35 +++
 rtl/control_sequencer.sv | 138 +++++++++++++
 tb/tb_control_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer and the ALU:
// sequencer states, opcode map, ALU operation codes, opcode classes and
// the per-state strobe decode.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_T7,
        ST_HALT
    } state_t;

    // Opcode map, ir[31:27]
    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_ANDI = 5'b01101;
    localparam logic [4:0] OPC_ORI  = 5'b01110;
    localparam logic [4:0] OPC_NOP  = 5'b11000;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    // ALU operation select codes, shared with the ALU
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;

    typedef enum logic [2:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LD,
        CLS_ST,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic pc_out;
        logic mdr_out;
        logic zlo_out;
        logic r_out;
        logic c_out;
        logic ba_out;
        logic mar_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic zlow_in;
        logic pc_in;
        logic r_in;
        logic gra;
        logic grb;
        logic grc;
        logic inc_pc;
        logic read;
        logic write;
    } strobes_t;

    // Moore strobe decode for a given state and opcode class
    function automatic strobes_t strobes_for(input state_t st, input op_class_t cls);
        strobes_t s;
        s = '0;
        unique case (st)
            ST_T0: begin
                s.pc_out  = 1'b1;
                s.mar_in  = 1'b1;
                s.inc_pc  = 1'b1;
                s.zlow_in = 1'b1;
            end
            ST_T1: begin
                s.zlo_out = 1'b1;
                s.pc_in   = 1'b1;
                s.read    = 1'b1;
                s.mdr_in  = 1'b1;
            end
            ST_T2: begin
                s.mdr_out = 1'b1;
                s.ir_in   = 1'b1;
            end
            ST_T3: begin
                if (cls == CLS_ALU_R) begin
                    s.grb   = 1'b1;
                    s.r_out = 1'b1;
                    s.y_in  = 1'b1;
                end else if (cls == CLS_ALU_I || cls == CLS_LD || cls == CLS_ST) begin
                    s.grb    = 1'b1;
                    s.ba_out = 1'b1;
                    s.r_out  = 1'b1;
                    s.y_in   = 1'b1;
                end
            end
            ST_T4: begin
                if (cls == CLS_ALU_R) begin
                    s.grc     = 1'b1;
                    s.r_out   = 1'b1;
                    s.zlow_in = 1'b1;
                end else if (cls == CLS_ALU_I || cls == CLS_LD || cls == CLS_ST) begin
                    s.c_out   = 1'b1;
                    s.zlow_in = 1'b1;
                end
            end
            ST_T5: begin
                if (cls == CLS_ALU_R || cls == CLS_ALU_I) begin
                    s.zlo_out = 1'b1;
                    s.gra     = 1'b1;
                    s.r_in    = 1'b1;
                end else if (cls == CLS_LD || cls == CLS_ST) begin
                    s.zlo_out = 1'b1;
                    s.mar_in  = 1'b1;
                end
            end
            ST_T6: begin
                if (cls == CLS_LD) begin
                    s.read   = 1'b1;
                    s.mdr_in = 1'b1;
                end else if (cls == CLS_ST) begin
                    // Read stays low so the MDR takes the bus value
                    s.gra    = 1'b1;
                    s.r_out  = 1'b1;
                    s.mdr_in = 1'b1;
                end
            end
            ST_T7: begin
                if (cls == CLS_LD) begin
                    s.mdr_out = 1'b1;
                    s.gra     = 1'b1;
                    s.r_in    = 1'b1;
                end else if (cls == CLS_ST) begin
                    s.write = 1'b1;
                end
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode: class, ALU operation and illegal flag.
module opcode_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class,
    output logic [4:0] alu_op,
    output logic       illegal
);

    // Map each opcode to its execute class and ALU code
    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_op   = ALU_NONE;
        illegal  = 1'b0;
        unique case (opcode)
            OPC_ADD:  begin op_class = CLS_ALU_R; alu_op = ALU_ADD; end
            OPC_SUB:  begin op_class = CLS_ALU_R; alu_op = ALU_SUB; end
            OPC_AND:  begin op_class = CLS_ALU_R; alu_op = ALU_AND; end
            OPC_OR:   begin op_class = CLS_ALU_R; alu_op = ALU_OR;  end
            OPC_ADDI: begin op_class = CLS_ALU_I; alu_op = ALU_ADD; end
            OPC_ANDI: begin op_class = CLS_ALU_I; alu_op = ALU_AND; end
            OPC_ORI:  begin op_class = CLS_ALU_I; alu_op = ALU_OR;  end
            OPC_LD:   begin op_class = CLS_LD;    alu_op = ALU_ADD; end
            OPC_ST:   begin op_class = CLS_ST;    alu_op = ALU_ADD; end
            OPC_NOP:  op_class = CLS_NOP;
            OPC_HALT: op_class = CLS_HALT;
            default: begin
                op_class = CLS_ILLEGAL;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: shared fetch T0-T2, decode, execute T3-T7 and HALT.
// All strobes are registered and change only just after a rising clk edge.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W = 5,
    parameter int IR_W = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [IR_W-1:0] ir,
    input  logic            stop,
    output logic            PC_out,
    output logic            MDR_out,
    output logic            Zlo_out,
    output logic            R_out,
    output logic            C_out,
    output logic            BAout,
    output logic            MARin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            Zlowin,
    output logic            PCin,
    output logic            Rin,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            IncPC,
    output logic            Read,
    output logic            Write,
    output logic [OP_W-1:0] op_sel,
    output logic            halted,
    output logic            illegal
);

    state_t    state_q;
    state_t    next_state;
    op_class_t cls_q;
    op_class_t next_cls;
    op_class_t dec_cls;
    logic [4:0] alu_q;
    logic [4:0] next_alu;
    logic [4:0] dec_alu;
    logic       dec_illegal;
    strobes_t   strb_q;
    logic [OP_W-1:0] op_sel_q;
    logic       halted_q;
    logic       illegal_q;
    logic       ir_unused;

    assign ir_unused = ^ir[IR_W-OP_W-1:0] ^ dec_illegal;

    opcode_decoder u_dec (
        .opcode   (5'(ir[IR_W-1 -: OP_W])),
        .op_class (dec_cls),
        .alu_op   (dec_alu),
        .illegal  (dec_illegal)
    );

    // Next-state and next-class selection
    always_comb begin
        // The class is captured on the T2->T3 edge, when ir holds the new word,
        // so T3's registered strobes can already depend on it.
        next_cls = (state_q == ST_T2) ? dec_cls : cls_q;
        next_alu = (state_q == ST_T2) ? dec_alu : alu_q;
        unique case (state_q)
            ST_RST: next_state = ST_T0;
            ST_T0:  next_state = ST_T1;
            ST_T1:  next_state = ST_T2;
            ST_T2:  next_state = ST_T3;
            ST_T3: begin
                unique case (cls_q)
                    CLS_ALU_R, CLS_ALU_I, CLS_LD, CLS_ST: next_state = ST_T4;
                    CLS_NOP: next_state = stop ? ST_HALT : ST_T0;
                    default: next_state = ST_HALT;
                endcase
            end
            ST_T4:  next_state = ST_T5;
            ST_T5: begin
                if (cls_q == CLS_LD || cls_q == CLS_ST)
                    next_state = ST_T6;
                else
                    next_state = stop ? ST_HALT : ST_T0;
            end
            ST_T6:   next_state = ST_T7;
            ST_T7:   next_state = stop ? ST_HALT : ST_T0;
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_RST;
        endcase
    end

    // State register with registered Moore outputs
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= ST_RST;
            cls_q     <= CLS_NOP;
            alu_q     <= ALU_NONE;
            strb_q    <= '0;
            op_sel_q  <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q  <= next_state;
            cls_q    <= next_cls;
            alu_q    <= next_alu;
            strb_q   <= strobes_for(next_state, next_cls);
            op_sel_q <= (next_state == ST_T4) ? OP_W'(next_alu) : '0;
            halted_q <= (next_state == ST_HALT);
            if (state_q == ST_T3 && cls_q == CLS_ILLEGAL)
                illegal_q <= 1'b1;
        end
    end

    assign PC_out  = strb_q.pc_out;
    assign MDR_out = strb_q.mdr_out;
    assign Zlo_out = strb_q.zlo_out;
    assign R_out   = strb_q.r_out;
    assign C_out   = strb_q.c_out;
    assign BAout   = strb_q.ba_out;
    assign MARin   = strb_q.mar_in;
    assign MDRin   = strb_q.mdr_in;
    assign IRin    = strb_q.ir_in;
    assign Yin     = strb_q.y_in;
    assign Zlowin  = strb_q.zlow_in;
    assign PCin    = strb_q.pc_in;
    assign Rin     = strb_q.r_in;
    assign Gra     = strb_q.gra;
    assign Grb     = strb_q.grb;
    assign Grc     = strb_q.grc;
    assign IncPC   = strb_q.inc_pc;
    assign Read    = strb_q.read;
    assign Write   = strb_q.write;
    assign op_sel  = op_sel_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a small datapath model executes programs from
// the strobes, and a queue of expected per-cycle strobe vectors is compared
// against the DUT outputs on every falling edge.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        stop;
    logic [31:0] irr;
    logic PC_out, MDR_out, Zlo_out, R_out, C_out, BAout;
    logic MARin, MDRin, IRin, Yin, Zlowin, PCin, Rin;
    logic Gra, Grb, Grc, IncPC, Read, Write, halted, illegal;
    logic [4:0] op_sel;

    always #5 clk = ~clk;

    control_sequencer #(.OP_W(5), .IR_W(32)) dut (
        .clk(clk), .clr(clr), .ir(irr), .stop(stop),
        .PC_out(PC_out), .MDR_out(MDR_out), .Zlo_out(Zlo_out), .R_out(R_out),
        .C_out(C_out), .BAout(BAout), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Zlowin(Zlowin), .PCin(PCin), .Rin(Rin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write), .op_sel(op_sel),
        .halted(halted), .illegal(illegal)
    );

    // Observed vector: {op_sel, illegal, halted, Write, Read, IncPC, Grc, Grb, Gra,
    // Rin, PCin, Zlowin, Yin, IRin, MDRin, MARin, BAout, C_out, R_out, Zlo_out, MDR_out, PC_out}
    logic [25:0] obs;
    assign obs = {op_sel, illegal, halted, Write, Read, IncPC, Grc, Grb, Gra, Rin, PCin,
                  Zlowin, Yin, IRin, MDRin, MARin, BAout, C_out, R_out, Zlo_out, MDR_out, PC_out};

    localparam logic [25:0] M_PC_OUT  = 26'd1 << 0;
    localparam logic [25:0] M_MDR_OUT = 26'd1 << 1;
    localparam logic [25:0] M_ZLO_OUT = 26'd1 << 2;
    localparam logic [25:0] M_R_OUT   = 26'd1 << 3;
    localparam logic [25:0] M_C_OUT   = 26'd1 << 4;
    localparam logic [25:0] M_BAOUT   = 26'd1 << 5;
    localparam logic [25:0] M_MARIN   = 26'd1 << 6;
    localparam logic [25:0] M_MDRIN   = 26'd1 << 7;
    localparam logic [25:0] M_IRIN    = 26'd1 << 8;
    localparam logic [25:0] M_YIN     = 26'd1 << 9;
    localparam logic [25:0] M_ZLOWIN  = 26'd1 << 10;
    localparam logic [25:0] M_PCIN    = 26'd1 << 11;
    localparam logic [25:0] M_RIN     = 26'd1 << 12;
    localparam logic [25:0] M_GRA     = 26'd1 << 13;
    localparam logic [25:0] M_GRB     = 26'd1 << 14;
    localparam logic [25:0] M_GRC     = 26'd1 << 15;
    localparam logic [25:0] M_INCPC   = 26'd1 << 16;
    localparam logic [25:0] M_READ    = 26'd1 << 17;
    localparam logic [25:0] M_WRITE   = 26'd1 << 18;
    localparam logic [25:0] M_HALTED  = 26'd1 << 19;
    localparam logic [25:0] M_ILLEGAL = 26'd1 << 20;

    int checks = 0;
    int errors = 0;

    logic [25:0] exp_q[$];
    string       tag_q[$];

    // Datapath model
    logic [31:0] regs [16];
    logic [31:0] mem  [256];
    logic [31:0] pc, mar, mdr, y, z;

    function automatic logic [25:0] opv(input logic [4:0] op);
        return {op, 21'd0};
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [18:0] c);
        return {op, ra, rb, c};
    endfunction

    task automatic push(input logic [25:0] v, input string t);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic push_fetch();
        push(M_PC_OUT | M_MARIN | M_INCPC | M_ZLOWIN, "T0");
        push(M_ZLO_OUT | M_PCIN | M_READ | M_MDRIN, "T1");
        push(M_MDR_OUT | M_IRIN, "T2");
    endtask

    task automatic push_alu_r(input logic [4:0] code);
        push(M_GRB | M_R_OUT | M_YIN, "alu_r_T3");
        push(M_GRC | M_R_OUT | M_ZLOWIN | opv(code), "alu_r_T4");
        push(M_ZLO_OUT | M_GRA | M_RIN, "alu_r_T5");
    endtask

    task automatic push_alu_i(input logic [4:0] code);
        push(M_GRB | M_BAOUT | M_R_OUT | M_YIN, "alu_i_T3");
        push(M_C_OUT | M_ZLOWIN | opv(code), "alu_i_T4");
        push(M_ZLO_OUT | M_GRA | M_RIN, "alu_i_T5");
    endtask

    task automatic push_mem_addr(input string t);
        push(M_GRB | M_BAOUT | M_R_OUT | M_YIN, {t, "_T3"});
        push(M_C_OUT | M_ZLOWIN | opv(5'b00011), {t, "_T4"});
        push(M_ZLO_OUT | M_MARIN, {t, "_T5"});
    endtask

    task automatic push_halt(input int n, input logic ill);
        for (int i = 0; i < n; i++)
            push(M_HALTED | (ill ? M_ILLEGAL : 26'd0), "HALT");
    endtask

    // Apply one cycle of strobes to the datapath model
    task automatic model_step();
        logic [31:0] bus, alu, cext;
        logic [3:0]  idx;
        cext = {{13{irr[18]}}, irr[18:0]};
        idx  = Gra ? irr[26:23] : (Grb ? irr[22:19] : irr[18:15]);
        bus  = 32'd0;
        if (PC_out)       bus = pc;
        else if (MDR_out) bus = mdr;
        else if (Zlo_out) bus = z;
        else if (R_out)   bus = (BAout && idx == 4'd0) ? 32'd0 : regs[idx];
        else if (C_out)   bus = cext;
        case (op_sel)
            5'b00011: alu = y + bus;
            5'b00100: alu = y - bus;
            5'b00101: alu = y & bus;
            5'b00110: alu = y | bus;
            default:  alu = 32'd0;
        endcase
        if (Write)  mem[mar[7:0]] = mdr;
        if (MDRin)  mdr = Read ? mem[mar[7:0]] : bus;
        if (Zlowin) z = IncPC ? pc + 32'd1 : alu;
        if (PCin)   pc = bus;
        if (Yin)    y = bus;
        if (IRin)   irr = bus;
        if (Rin)    regs[idx] = bus;
        if (MARin)  mar = bus;
    endtask

    // One cycle: compare the next expected vector, then advance the model
    task automatic tick();
        logic [25:0] e;
        string t;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s: strobes got %h expected %h", t, obs, e);
            end
        end
        model_step();
    endtask

    task automatic drain();
        int n;
        n = exp_q.size();
        repeat (n) tick();
    endtask

    // Hold reset for two edges and clear the model; program is loaded afterwards
    task automatic prep();
        clr  = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        for (int i = 0; i < 16; i++) regs[i] = 32'd0;
        pc = 0; mar = 0; mdr = 0; y = 0; z = 0; irr = 0;
        push(26'd0, "reset");
        push(26'd0, "reset");
        tick();
        tick();
    endtask

    task automatic check_val(input string t, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", t, got, want);
        end
    endtask

    task automatic test_reset();
        prep();
        mem[0] = enc(5'b11011, 4'd0, 4'd0, 19'd0);
        clr = 1'b1;
        push_fetch();
        push(26'd0, "halt_T3");
        push_halt(2, 1'b0);
        drain();
    endtask

    task automatic test_addi();
        prep();
        regs[6] = 32'h50;
        mem[0] = enc(5'b01100, 4'd5, 4'd6, 19'h7FFF9);
        mem[1] = enc(5'b11011, 4'd0, 4'd0, 19'd0);
        clr = 1'b1;
        push_fetch();
        push_alu_i(5'b00011);
        push_fetch();
        push(26'd0, "halt_T3");
        push_halt(3, 1'b0);
        drain();
        check_val("addi_r5", regs[5], 32'h49);
    endtask

    task automatic test_alu_reg();
        prep();
        regs[2] = 32'd7;
        regs[3] = 32'd5;
        mem[0] = enc(5'b00011, 4'd1, 4'd2, {4'd3, 15'd0});
        mem[1] = enc(5'b00100, 4'd4, 4'd2, {4'd3, 15'd0});
        mem[2] = enc(5'b00101, 4'd6, 4'd2, {4'd3, 15'd0});
        mem[3] = enc(5'b00110, 4'd7, 4'd2, {4'd3, 15'd0});
        mem[4] = enc(5'b11011, 4'd0, 4'd0, 19'd0);
        clr = 1'b1;
        push_fetch(); push_alu_r(5'b00011);
        push_fetch(); push_alu_r(5'b00100);
        push_fetch(); push_alu_r(5'b00101);
        push_fetch(); push_alu_r(5'b00110);
        push_fetch(); push(26'd0, "halt_T3");
        push_halt(2, 1'b0);
        drain();
        check_val("add_r1", regs[1], 32'h0C);
        check_val("sub_r4", regs[4], 32'h02);
        check_val("and_r6", regs[6], 32'h05);
        check_val("or_r7",  regs[7], 32'h07);
    endtask

    task automatic test_ld_st();
        prep();
        mem[8'h10] = 32'hDEAD;
        mem[0] = enc(5'b00000, 4'd4, 4'd0, 19'h10);
        mem[1] = enc(5'b00010, 4'd4, 4'd0, 19'h11);
        mem[2] = enc(5'b11011, 4'd0, 4'd0, 19'd0);
        clr = 1'b1;
        push_fetch(); push_mem_addr("ld");
        push(M_READ | M_MDRIN, "ld_T6");
        push(M_MDR_OUT | M_GRA | M_RIN, "ld_T7");
        push_fetch(); push_mem_addr("st");
        push(M_GRA | M_R_OUT | M_MDRIN, "st_T6");
        push(M_WRITE, "st_T7");
        push_fetch(); push(26'd0, "halt_T3");
        push_halt(2, 1'b0);
        drain();
        check_val("ld_r4", regs[4], 32'hDEAD);
        check_val("st_mem11", mem[8'h11], 32'hDEAD);
    endtask

    task automatic test_nop_halt();
        prep();
        mem[0] = enc(5'b11000, 4'd0, 4'd0, 19'd0);
        mem[1] = enc(5'b11011, 4'd0, 4'd0, 19'd0);
        clr = 1'b1;
        push_fetch(); push(26'd0, "nop_T3");
        push_fetch(); push(26'd0, "halt_T3");
        push_halt(12, 1'b0);
        drain();
    endtask

    task automatic test_illegal();
        prep();
        mem[0] = enc(5'b11111, 4'd0, 4'd0, 19'd0);
        mem[1] = enc(5'b11011, 4'd0, 4'd0, 19'd0);
        clr = 1'b1;
        push_fetch(); push(26'd0, "illegal_T3");
        push_halt(3, 1'b1);
        drain();
        clr = 1'b0;
        push(26'd0, "illegal_clr");
        tick();
        clr = 1'b1;
        pc = 32'd1;
        push_fetch(); push(26'd0, "after_clr_T3");
        push_halt(1, 1'b0);
        drain();
    endtask

    task automatic test_stop();
        prep();
        regs[2] = 32'd7;
        regs[3] = 32'd5;
        mem[0] = enc(5'b00011, 4'd1, 4'd2, {4'd3, 15'd0});
        mem[1] = enc(5'b11000, 4'd0, 4'd0, 19'd0);
        clr = 1'b1;
        push_fetch(); push_alu_r(5'b00011);
        push_halt(3, 1'b0);
        repeat (5) tick();
        stop = 1'b1;
        drain();
        stop = 1'b0;
        check_val("stop_r1", regs[1], 32'h0C);
    endtask

    task automatic test_clr_mid();
        prep();
        regs[4] = 32'h1234;
        mem[8'h10] = 32'hBEEF;
        mem[0] = enc(5'b00000, 4'd4, 4'd0, 19'h10);
        clr = 1'b1;
        push_fetch(); push_mem_addr("ldmid");
        push(M_READ | M_MDRIN, "ldmid_T6");
        drain();
        clr = 1'b0;
        push(26'd0, "mid_rst");
        push(26'd0, "mid_rst");
        drain();
        check_val("mid_r4_kept", regs[4], 32'h1234);
        clr = 1'b1;
        pc = 32'd0;
        push(M_PC_OUT | M_MARIN | M_INCPC | M_ZLOWIN, "mid_T0");
        drain();
    endtask

    initial begin
        clr  = 1'b0;
        stop = 1'b0;
        irr  = 32'd0;
        test_reset();
        test_addi();
        test_alu_reg();
        test_ld_st();
        test_nop_halt();
        test_illegal();
        test_stop();
        test_clr_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
